// File: rtl/pe_cu_pkg.sv
// Shared types for the pe_cu_seq fetch-and-reduce controller:
// FSM state encoding and reduction mode codes.
package pe_cu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_SUM  = 2'd0;
    localparam logic [1:0] MODE_MAX  = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/pe_cu_seq_if.sv
// Control, memory-read and result handshake bundle of pe_cu_seq.
// The master side is the environment (requester plus memory); the slave side is the controller.
interface pe_cu_seq_if #(
    parameter int DW = 32,
    parameter int AW = 3,
    parameter int OW = 8
) ();
    logic          start;
    logic [AW-1:0] base_addr;
    logic [1:0]    mode;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [OW-1:0] result;
    logic          result_valid;
    logic          result_ready;

    modport master (
        output start, base_addr, mode, mem_rdata, result_ready,
        input  mem_en, mem_addr, busy, result, result_valid
    );

    modport slave (
        input  start, base_addr, mode, mem_rdata, result_ready,
        output mem_en, mem_addr, busy, result, result_valid
    );
endinterface

// File: rtl/pe_reduce.sv
// Reduction accumulator: folds one OW-bit word per enabled cycle using sum, unsigned max or xor.
// clear has priority over en and returns the accumulator to zero.
module pe_reduce
    import pe_cu_pkg::*;
#(
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [OW-1:0] w,
    output logic [OW-1:0] acc
);

    logic [OW-1:0] acc_q;
    logic [OW-1:0] acc_d;

    // The reserved mode code folds like a sum.
    function automatic logic [OW-1:0] reduce_step(input logic [1:0]    m,
                                                  input logic [OW-1:0] a,
                                                  input logic [OW-1:0] b);
        logic [OW-1:0] r;
        case (m)
            MODE_MAX: r = (b > a) ? b : a;
            MODE_XOR: r = a ^ b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

    // Next accumulator value.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = {OW{1'b0}};
        end else if (en) begin
            acc_d = reduce_step(mode, acc_q, w);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {OW{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/pe_cu_seq.sv
// Fetch-and-reduce controller: reads N_WORDS consecutive words (address wraps) from a
// 1-cycle-latency memory, reduces their low OW bits and holds the result until accepted.
module pe_cu_seq
    import pe_cu_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 3,
    parameter int N_WORDS = 8,
    parameter int OW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    pe_cu_seq_if.slave  cu
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_WORDS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]    mode_q, mode_d;
    logic          mem_en_q, mem_en_d;
    logic          busy_q, busy_d;
    logic          result_valid_q, result_valid_d;
    logic          rd_vld_q;
    logic          acc_clear_s;
    logic [OW-1:0] acc_s;

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mode_d      = mode_q;
        acc_clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cu.start) begin
                    state_d     = ST_FETCH;
                    mem_addr_d  = cu.base_addr;
                    mode_d      = cu.mode;
                    cnt_d       = {AW{1'b0}};
                    acc_clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Address increments modulo 2^AW; its value after the last issue is unused.
                mem_addr_d = mem_addr_q + AW'(1);
                cnt_d      = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (cu.result_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_en_d       = (state_d == ST_FETCH);
        busy_d         = (state_d != ST_IDLE);
        result_valid_d = (state_d == ST_DONE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= {AW{1'b0}};
            mem_addr_q     <= {AW{1'b0}};
            mode_q         <= MODE_SUM;
            mem_en_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            rd_vld_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_addr_q     <= mem_addr_d;
            mode_q         <= mode_d;
            mem_en_q       <= mem_en_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            rd_vld_q       <= mem_en_q;
        end
    end

    pe_reduce #(
        .OW (OW)
    ) u_reduce (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (acc_clear_s),
        .en    (rd_vld_q),
        .mode  (mode_q),
        .w     (cu.mem_rdata[OW-1:0]),
        .acc   (acc_s)
    );

    assign cu.mem_en       = mem_en_q;
    assign cu.mem_addr     = mem_addr_q;
    assign cu.busy         = busy_q;
    assign cu.result       = acc_s;
    assign cu.result_valid = result_valid_q;

endmodule

// File: tb/tb_pe_cu_seq.sv
// Self-checking bench for pe_cu_seq: a synchronous memory model, an expected-result
// scoreboard queue and one task per scenario.
module tb_pe_cu_seq;
    import pe_cu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int N  = 8;
    localparam int OW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_cu_seq_if #(.DW(DW), .AW(AW), .OW(OW)) bus ();

    pe_cu_seq #(.DW(DW), .AW(AW), .N_WORDS(N), .OW(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cu    (bus)
    );

    logic [DW-1:0] mem [0:N-1];

    // Synchronous-read memory with one cycle of latency.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    logic [OW-1:0] exp_q [$];
    logic [AW-1:0] obs_addr [$];
    int            obs_cyc [$];
    logic [OW-1:0] obs_result;
    int            done_cyc;

    task automatic fill_mem(input int pattern);
        for (int a = 0; a < N; a++) begin
            logic [DW-1:0] w;
            w = $urandom;
            if (pattern == 0) w[7:0] = 8'(a + 1);
            else if (pattern == 1) w[7:0] = 8'hFF;
            mem[a] = w;
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [AW-1:0] base, input logic [1:0] m);
        logic [OW-1:0] acc;
        logic [OW-1:0] w;
        logic [AW-1:0] a;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            a = base + AW'(k);
            w = mem[a][OW-1:0];
            if (m == 2'd1) begin
                if (w > acc) acc = w;
            end else if (m == 2'd2) begin
                acc = acc ^ w;
            end else begin
                acc = acc + w;
            end
        end
        return acc;
    endfunction

    // Pulses start for one cycle, then scrambles base/mode; returns 1ns into cycle T+1.
    task automatic start_op(input logic [AW-1:0] base, input logic [1:0] m, input logic [OW-1:0] exp);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.mode      = m;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.mode      = 2'($urandom);
    endtask

    // Records issued addresses (cycle offsets from start) until result_valid or budget expiry.
    task automatic capture_op(input int budget);
        obs_addr.delete();
        obs_cyc.delete();
        done_cyc   = -1;
        obs_result = '0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                obs_addr.push_back(bus.mem_addr);
                obs_cyc.push_back(c);
            end
            if (bus.result_valid) begin
                done_cyc   = c;
                obs_result = bus.result;
                break;
            end
        end
    endtask

    task automatic handshake();
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
        checks++; if (bus.mem_addr !== 3'd0) begin failures++; $display("FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL reset_result: got %0h expected 0", bus.result); end
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL reset_result_valid: got %b expected 0", bus.result_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_reductions();
        int            pat   [4] = '{0, 0, 0, 1};
        logic [AW-1:0] bases [4] = '{3'd0, 3'd6, 3'd0, 3'd0};
        logic [1:0]    modes [4] = '{MODE_SUM, MODE_MAX, MODE_XOR, MODE_SUM};
        logic [OW-1:0] exps  [4] = '{8'h24, 8'h08, 8'h08, 8'hF8};
        for (int t = 0; t < 4; t++) begin
            logic [OW-1:0] exp;
            fill_mem(pat[t]);
            start_op(bases[t], modes[t], exps[t]);
            capture_op(40);
            checks++;
            if (obs_addr.size() != N) begin failures++; $display("FAIL red%0d_issue_count: got %0d expected %0d", t, obs_addr.size(), N); end
            for (int k = 0; k < obs_addr.size() && k < N; k++) begin
                logic [AW-1:0] ea;
                ea = bases[t] + AW'(k);
                checks++;
                if (obs_addr[k] !== ea || obs_cyc[k] != k + 1) begin
                    failures++;
                    $display("FAIL red%0d_addr%0d: got addr %0d at T+%0d expected addr %0d at T+%0d", t, k, obs_addr[k], obs_cyc[k], ea, k + 1);
                end
            end
            checks++;
            if (done_cyc != N + 2) begin failures++; $display("FAIL red%0d_done_cycle: got T+%0d expected T+%0d", t, done_cyc, N + 2); end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            checks++;
            if (obs_result !== exp) begin failures++; $display("FAIL red%0d_result: got %0h expected %0h", t, obs_result, exp); end
            handshake();
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
                failures++; $display("FAIL red%0d_idle_after_ready: got busy=%b valid=%b expected 0 0", t, bus.busy, bus.result_valid);
            end
        end
    endtask

    task automatic test_hold_and_ignore();
        logic [OW-1:0] exp;
        fill_mem(0);
        start_op(3'd0, MODE_SUM, 8'h24);
        capture_op(40);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if (done_cyc != N + 2) begin failures++; $display("FAIL hold_done_cycle: got T+%0d expected T+%0d", done_cyc, N + 2); end
        for (int i = 0; i < 5; i++) begin
            bus.start     = (i == 2);
            bus.base_addr = 3'd5;
            @(negedge clk);
            checks++;
            if (bus.result !== exp || bus.result_valid !== 1'b1 || bus.mem_en !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL hold_cycle%0d: got result=%0h valid=%b mem_en=%b busy=%b expected %0h 1 0 1", i, bus.result, bus.result_valid, bus.mem_en, bus.busy, exp);
            end
        end
        bus.start = 1'b1;
        handshake();
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL hold_release: got valid=%b busy=%b expected 0 0", bus.result_valid, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL hold_start_ignored: got mem_en=%b busy=%b expected 0 0", bus.mem_en, bus.busy);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [OW-1:0] exp;
        fill_mem(0);
        start_op(3'd0, MODE_SUM, 8'h24);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 3'd3) begin
            failures++; $display("FAIL rst_pre_fetch: got mem_en=%b addr=%0d expected 1 3", bus.mem_en, bus.mem_addr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            failures++; $display("FAIL rst_abort: got mem_en=%b busy=%b valid=%b expected 0 0 0", bus.mem_en, bus.busy, bus.result_valid);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        fill_mem(2);
        start_op(3'd2, MODE_SUM, model(3'd2, MODE_SUM));
        capture_op(40);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if (done_cyc != N + 2 || obs_result !== exp) begin
            failures++; $display("FAIL rst_restart: got result=%0h at T+%0d expected %0h at T+%0d", obs_result, done_cyc, exp, N + 2);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] b;
            logic [1:0]    m;
            logic [OW-1:0] exp;
            fill_mem(2);
            b = AW'($urandom);
            m = 2'($urandom_range(0, 3));
            start_op(b, m, model(b, m));
            capture_op(40);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            checks++;
            if (obs_result !== exp || done_cyc != N + 2 || obs_addr.size() != N) begin
                failures++;
                $display("FAIL b2b%0d_mode%0d_base%0d: got result=%0h at T+%0d issues=%0d expected %0h at T+%0d issues=%0d",
                         t, m, b, obs_result, done_cyc, obs_addr.size(), exp, N + 2, N);
            end
            handshake();
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.base_addr    = '0;
        bus.mode         = MODE_SUM;
        bus.result_ready = 1'b0;
        test_reset();
        test_reductions();
        test_hold_and_ignore();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_cu_seq.md
PE_CU_SEQ -- requirements
Module: pe_cu_seq

Interface
REQ-001 The block SHALL have parameter DW, default 32, memory word width in bits.
REQ-002 The block SHALL have parameter AW, default 3, memory address width in bits.
REQ-003 The block SHALL have parameter N_WORDS, default 8, words fetched per operation; legal range 1..2^AW.
REQ-004 The block SHALL have parameter OW, default 8, result width in bits; OW <= DW.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, operation request, sampled only in IDLE.
REQ-008 The block SHALL have port base_addr, input, AW, first fetch address, latched with start.
REQ-009 The block SHALL have port mode, input, 2, reduction select, latched with start: 0 sum, 1 max, 2 xor, 3 reserved (treated as sum).
REQ-010 The block SHALL have port mem_en, output, 1, memory read enable.
REQ-011 The block SHALL have port mem_addr, output, AW, memory read address.
REQ-012 The block SHALL have port mem_rdata, input, DW, read data, valid one cycle after mem_en (synchronous BRAM, 1-cycle latency).
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port result, output, OW, reduction result.
REQ-015 The block SHALL have port result_valid, output, 1, result available.
REQ-016 The block SHALL have port result_ready, input, 1, consumer accepts result.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, DRAIN and DONE.
REQ-018 In IDLE with start=1 at cycle T, the block SHALL latch base_addr and mode, clear the accumulator, and enter FETCH at T+1.
REQ-019 In FETCH, the block SHALL assert mem_en for exactly N_WORDS consecutive cycles, with mem_addr = base_addr + k mod 2^AW for k = 0..N_WORDS-1 (wrap-around).
REQ-020 After the last issue, the block SHALL enter DRAIN for one cycle to absorb the final read data.
REQ-021 Each returned word SHALL be reduced using its low OW bits w: sum acc = (acc + w) mod 2^OW; max acc = unsigned max(acc, w); xor acc = acc ^ w; the accumulator initial value SHALL be 0.
REQ-022 The block SHALL enter DONE at T+N_WORDS+2 with result_valid=1 and result = final accumulator.
REQ-023 In DONE, result and result_valid SHALL hold stable until result_ready=1, then the block SHALL return to IDLE the next cycle with result_valid=0.
REQ-024 The block SHALL ignore start when not in IDLE, including start coincident with the result_ready handshake in DONE.
REQ-025 The block SHALL ignore changes to base_addr and mode after latching.
REQ-026 mem_en SHALL be 0 outside FETCH, and mem_addr SHALL be don't-care when mem_en=0.

Reset
REQ-027 On rst_n=0, the block SHALL immediately enter IDLE, with mem_en=0, mem_addr=0, busy=0, result=0, result_valid=0 and the accumulator at 0, regardless of state.
REQ-028 A reset during FETCH/DRAIN/DONE SHALL abort the operation, produce no result_valid, and accept a new start after rst_n is released.

Structure
REQ-029 Package pe_cu_pkg SHALL hold the state enum and mode encodings (MODE_SUM, MODE_MAX, MODE_XOR).
REQ-030 The reduction datapath SHALL be sub-module pe_reduce (inputs: clear, en, mode, w; output: acc).

Verification
REQ-031 mem[a] low byte = a+1, base 0, mode 0, start at T -> mem_addr 0..7 at T+1..T+8, result=0x24 with result_valid at T+10.
REQ-032 Same memory, base 6, mode 1 -> mem_addr sequence 6,7,0,1,2,3,4,5 and result=0x08.
REQ-033 Same memory, mode 2 -> result=0x08; all low bytes 0xFF, mode 0 -> result=0xF8 (overflow wraps).
REQ-034 result_ready held low 5 cycles in DONE, with start pulsed -> result stable, no new fetch, IDLE one cycle after ready.
REQ-035 rst_n low at T+4 mid-FETCH -> mem_en=0 and busy=0 immediately; a new start then completes correctly.
